// File: rtl/data_mem_access_if.sv
// Bus bundle between the data-memory access unit, the pipeline/decoder side and the data BRAM.
interface data_mem_access_if #(
   parameter int unsigned ADDR_WIDTH      = 64,
   parameter int unsigned BRAM_ADDR_WIDTH = 12
);
   logic                       mem_read;
   logic                       mem_write;
   logic [1:0]                 bit_width;
   logic                       sign_extend;
   logic [ADDR_WIDTH-1:0]      addr;
   logic [63:0]                wdata;
   logic [63:0]                bram_rdata;
   logic                       mem_stall;
   logic [63:0]                rdata;
   logic                       rdata_valid;
   logic                       misaligned;
   logic                       bram_en;
   logic [7:0]                 bram_we;
   logic [BRAM_ADDR_WIDTH-1:0] bram_addr;
   logic [63:0]                bram_wdata;

   modport slave (
      input  mem_read, mem_write, bit_width, sign_extend, addr, wdata, bram_rdata,
      output mem_stall, rdata, rdata_valid, misaligned, bram_en, bram_we, bram_addr, bram_wdata
   );

   modport master (
      output mem_read, mem_write, bit_width, sign_extend, addr, wdata, bram_rdata,
      input  mem_stall, rdata, rdata_valid, misaligned, bram_en, bram_we, bram_addr, bram_wdata
   );
endinterface

// File: rtl/data_mem_access.sv
// Sequential load/store unit in front of a 64-bit synchronous data BRAM.
// DATA_MEM_MISALIGNED_EN: split word-crossing accesses into two beats; otherwise fault on misalignment.
module data_mem_access #(
   parameter int unsigned ADDR_WIDTH      = 64,
   parameter int unsigned BRAM_ADDR_WIDTH = 12,
   parameter int unsigned BRAM_LATENCY    = 1
) (
   input  logic                clk,
   input  logic                rst,
   data_mem_access_if.slave    bus
);
   localparam int unsigned IDX_W = BRAM_ADDR_WIDTH;
   localparam int unsigned CNT_W = 2;

   typedef enum logic [2:0] {IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, DONE} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q;
   logic [2:0]       off_q;
   logic [1:0]       bw_q;
   logic             sx_q;
   logic             wr_q;
   logic [63:0]      wdata_q;
   logic [63:0]      beat0_q;
   logic [63:0]      rdata_q, rdata_d;
   logic             rdata_valid_q, rdata_valid_d;
   logic             misaligned_q, misaligned_d;

   logic             accept_c;
   logic [15:0]      lanes16_c;
   logic [127:0]     wide_c;
   logic [63:0]      beat0_now_c, beat1_now_c, load_c;
   logic             unused_c;

   function automatic logic [7:0] size_lanes(input logic [1:0] bw);
      case (bw)
         2'd0:    return 8'h01;
         2'd1:    return 8'h03;
         2'd2:    return 8'h0F;
         default: return 8'hFF;
      endcase
   endfunction

   function automatic logic [63:0] lane_mask(input logic [7:0] lanes);
      logic [63:0] m;
      for (int i = 0; i < 8; i++) m[i*8 +: 8] = {8{lanes[i]}};
      return m;
   endfunction

   function automatic logic [63:0] extend(input logic [63:0] raw, input logic [1:0] bw, input logic sx);
      case (bw)
         2'd0:    return {{56{sx & raw[7]}},  raw[7:0]};
         2'd1:    return {{48{sx & raw[15]}}, raw[15:0]};
         2'd2:    return {{32{sx & raw[31]}}, raw[31:0]};
         default: return raw;
      endcase
   endfunction

   assign accept_c  = (state_q == IDLE) && (bus.mem_read || bus.mem_write);
   assign lanes16_c = {8'h00, size_lanes(bw_q)} << off_q;
   assign wide_c    = {64'h0, wdata_q & lane_mask(size_lanes(bw_q))} << {off_q, 3'b000};

   // Beat data arrives on the last WAIT cycle, so bypass it into the load result directly
   assign beat0_now_c = (state_q == WAIT0) ? bus.bram_rdata : beat0_q;

`ifdef DATA_MEM_MISALIGNED_EN
   logic [63:0] beat1_q;
   logic        crossing_c;

   assign crossing_c  = (5'(off_q) + (5'd1 << bw_q)) > 5'd8;
   assign beat1_now_c = (state_q == WAIT1) ? bus.bram_rdata : beat1_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                   beat1_q <= '0;
      else if (state_q == WAIT1 && cnt_q == '0)  beat1_q <= bus.bram_rdata;
   end

   assign unused_c = ^bus.addr[ADDR_WIDTH-1:IDX_W+3];
`else
   logic mis_in_c;

   assign mis_in_c    = |(bus.addr[2:0] & 3'((4'd1 << bus.bit_width) - 4'd1));
   assign beat1_now_c = '0;
   assign unused_c    = ^{bus.addr[ADDR_WIDTH-1:IDX_W+3], lanes16_c[15:8], wide_c[127:64]};
`endif

   assign load_c = extend(64'({beat1_now_c, beat0_now_c} >> {off_q, 3'b000}), bw_q, sx_q);

   // Request capture and beat0 capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q   <= '0;
         off_q   <= '0;
         bw_q    <= '0;
         sx_q    <= 1'b0;
         wr_q    <= 1'b0;
         wdata_q <= '0;
         beat0_q <= '0;
      end else begin
         if (accept_c) begin
            idx_q   <= bus.addr[IDX_W+2:3];
            off_q   <= bus.addr[2:0];
            bw_q    <= bus.bit_width;
            sx_q    <= bus.sign_extend;
            wr_q    <= ~bus.mem_read;
            wdata_q <= bus.wdata;
         end
         if (state_q == WAIT0 && cnt_q == '0) beat0_q <= bus.bram_rdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         rdata_q       <= '0;
         rdata_valid_q <= 1'b0;
         misaligned_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         rdata_q       <= rdata_d;
         rdata_valid_q <= rdata_valid_d;
         misaligned_q  <= misaligned_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      rdata_d        = rdata_q;
      rdata_valid_d  = 1'b0;
      misaligned_d   = 1'b0;
      bus.bram_en    = 1'b0;
      bus.bram_we    = '0;
      bus.bram_addr  = idx_q;
      bus.bram_wdata = '0;

      case (state_q)
         IDLE: begin
            if (accept_c) begin
`ifdef DATA_MEM_MISALIGNED_EN
               state_d = ISSUE0;
`else
               if (mis_in_c) begin
                  state_d      = DONE;
                  misaligned_d = 1'b1;
               end else begin
                  state_d = ISSUE0;
               end
`endif
            end
         end
         ISSUE0: begin
            bus.bram_en = 1'b1;
            if (wr_q) begin
               bus.bram_we    = lanes16_c[7:0];
               bus.bram_wdata = wide_c[63:0];
`ifdef DATA_MEM_MISALIGNED_EN
               state_d = crossing_c ? ISSUE1 : DONE;
`else
               state_d = DONE;
`endif
            end else begin
               state_d = WAIT0;
               cnt_d   = CNT_W'(BRAM_LATENCY - 1);
            end
         end
         WAIT0: begin
            if (cnt_q == '0) begin
`ifdef DATA_MEM_MISALIGNED_EN
               if (crossing_c) begin
                  state_d = ISSUE1;
               end else begin
                  state_d       = DONE;
                  rdata_d       = load_c;
                  rdata_valid_d = 1'b1;
               end
`else
               state_d       = DONE;
               rdata_d       = load_c;
               rdata_valid_d = 1'b1;
`endif
            end else begin
               cnt_d = CNT_W'(cnt_q - 1'b1);
            end
         end
`ifdef DATA_MEM_MISALIGNED_EN
         ISSUE1: begin
            bus.bram_en   = 1'b1;
            bus.bram_addr = IDX_W'(idx_q + 1'b1);
            if (wr_q) begin
               bus.bram_we    = lanes16_c[15:8];
               bus.bram_wdata = wide_c[127:64];
               state_d        = DONE;
            end else begin
               state_d = WAIT1;
               cnt_d   = CNT_W'(BRAM_LATENCY - 1);
            end
         end
         WAIT1: begin
            if (cnt_q == '0) begin
               state_d       = DONE;
               rdata_d       = load_c;
               rdata_valid_d = 1'b1;
            end else begin
               cnt_d = CNT_W'(cnt_q - 1'b1);
            end
         end
`endif
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Stall is driven from raw requests only, never from decoder-gated enables
   assign bus.mem_stall = ~rst & (accept_c || state_q == ISSUE0 || state_q == WAIT0 ||
                                  state_q == ISSUE1 || state_q == WAIT1);
   assign bus.rdata       = rdata_q;
   assign bus.rdata_valid = rdata_valid_q;
   assign bus.misaligned  = misaligned_q;
endmodule

// File: tb/tb_data_mem_access.sv
// Directed bench for data_mem_access with a 1-cycle-latency BRAM model.
module tb_data_mem_access;
   localparam int unsigned AW  = 64;
   localparam int unsigned BAW = 12;
   localparam int unsigned LAT = 1;

   typedef struct {
      logic        wr;
      logic [1:0]  bw;
      logic        sx;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [63:0] exp_rdata;
      int          exp_done;
      logic        exp_mis;
      int          exp_beats;
      logic [7:0]  exp_we0;
      logic [11:0] exp_ba0;
      logic [63:0] exp_wd0;
      logic [7:0]  exp_we1;
      logic [11:0] exp_ba1;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   data_mem_access_if #(.ADDR_WIDTH(AW), .BRAM_ADDR_WIDTH(BAW)) bif();

   data_mem_access #(.ADDR_WIDTH(AW), .BRAM_ADDR_WIDTH(BAW), .BRAM_LATENCY(LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   logic [63:0] mem [0:4095];
   logic [63:0] rd_q;

   always @(posedge clk) begin
      if (bif.bram_en) begin
         for (int b = 0; b < 8; b++)
            if (bif.bram_we[b]) mem[bif.bram_addr][b*8 +: 8] <= bif.bram_wdata[b*8 +: 8];
         rd_q <= mem[bif.bram_addr];
      end
   end
   assign bif.bram_rdata = rd_q;

   int n_vec = 0;
   int n_err = 0;

   int          o_done, o_valid, o_mis, o_beats;
   logic        o_stall0;
   logic [7:0]  o_we0, o_we1;
   logic [11:0] o_ba0, o_ba1;
   logic [63:0] o_wd0, o_wd1, o_rdata;

   vec_t vt [20];

   task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s [%0d]: got %h expected %h", nm, idx, act, exp);
      end
   endtask

   task automatic chk_i(input string nm, input int idx, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s [%0d]: got %0d expected %0d", nm, idx, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic wr, input logic [1:0] bw, input logic sx,
                               input logic [63:0] a, input logic [63:0] wd, input logic [63:0] er,
                               input int done, input logic mis, input int beats,
                               input logic [7:0] we0, input logic [11:0] ba0, input logic [63:0] wd0,
                               input logic [7:0] we1, input logic [11:0] ba1);
      vec_t v;
      v.wr = wr; v.bw = bw; v.sx = sx; v.addr = a; v.wdata = wd; v.exp_rdata = er;
      v.exp_done = done; v.exp_mis = mis; v.exp_beats = beats;
      v.exp_we0 = we0; v.exp_ba0 = ba0; v.exp_wd0 = wd0; v.exp_we1 = we1; v.exp_ba1 = ba1;
      return v;
   endfunction

   // Issue one request in cycle 0, then observe cycles 1..8
   task automatic run(input logic wr, input logic [1:0] bw, input logic sx,
                      input logic [63:0] a, input logic [63:0] wd);
      @(negedge clk);
      bif.mem_read = ~wr; bif.mem_write = wr; bif.bit_width = bw;
      bif.sign_extend = sx; bif.addr = a; bif.wdata = wd;
      #1;
      o_stall0 = bif.mem_stall;
      o_done = -1; o_valid = -1; o_mis = -1; o_beats = 0;
      o_we0 = '0; o_we1 = '0; o_ba0 = '0; o_ba1 = '0; o_wd0 = '0; o_wd1 = '0;
      @(posedge clk);
      #1;
      bif.mem_read = 1'b0; bif.mem_write = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (o_done < 0 && !bif.mem_stall) o_done = k;
         if (o_valid < 0 && bif.rdata_valid) o_valid = k;
         if (o_mis < 0 && bif.misaligned) o_mis = k;
         if (bif.bram_en) begin
            if (o_beats == 0) begin
               o_we0 = bif.bram_we; o_ba0 = bif.bram_addr; o_wd0 = bif.bram_wdata;
            end else if (o_beats == 1) begin
               o_we1 = bif.bram_we; o_ba1 = bif.bram_addr; o_wd1 = bif.bram_wdata;
            end
            o_beats++;
         end
      end
      o_rdata = bif.rdata;
   endtask

   initial begin
      vt[0]  = mk(1'b1, 2'd3, 1'b0, 64'h08, 64'hF0E0D0C0B0A09080, 64'h0, 2, 1'b0, 1, 8'hFF, 12'h1, 64'hF0E0D0C0B0A09080, 8'h0, 12'h0);
      vt[1]  = mk(1'b1, 2'd3, 1'b0, 64'h10, 64'h0, 64'h0, 2, 1'b0, 1, 8'hFF, 12'h2, 64'h0, 8'h0, 12'h0);
      vt[2]  = mk(1'b0, 2'd2, 1'b1, 64'h0C, 64'h0, 64'hFFFFFFFFF0E0D0C0, 3, 1'b0, 1, 8'h0, 12'h1, 64'h0, 8'h0, 12'h0);
      vt[3]  = mk(1'b0, 2'd0, 1'b0, 64'h0F, 64'h0, 64'h00000000000000F0, 3, 1'b0, 1, 8'h0, 12'h1, 64'h0, 8'h0, 12'h0);
      vt[4]  = mk(1'b0, 2'd0, 1'b1, 64'h0F, 64'h0, 64'hFFFFFFFFFFFFFFF0, 3, 1'b0, 1, 8'h0, 12'h1, 64'h0, 8'h0, 12'h0);
      vt[5]  = mk(1'b0, 2'd1, 1'b0, 64'h0A, 64'h0, 64'h000000000000B0A0, 3, 1'b0, 1, 8'h0, 12'h1, 64'h0, 8'h0, 12'h0);
      vt[6]  = mk(1'b0, 2'd1, 1'b1, 64'h08, 64'h0, 64'hFFFFFFFFFFFF9080, 3, 1'b0, 1, 8'h0, 12'h1, 64'h0, 8'h0, 12'h0);
      vt[7]  = mk(1'b0, 2'd3, 1'b0, 64'h08, 64'h0, 64'hF0E0D0C0B0A09080, 3, 1'b0, 1, 8'h0, 12'h1, 64'h0, 8'h0, 12'h0);
      vt[8]  = mk(1'b0, 2'd2, 1'b0, 64'h08, 64'h0, 64'h00000000B0A09080, 3, 1'b0, 1, 8'h0, 12'h1, 64'h0, 8'h0, 12'h0);
      vt[9]  = mk(1'b1, 2'd2, 1'b0, 64'h14, 64'h12345678CAFEF00D, 64'h00000000B0A09080, 2, 1'b0, 1, 8'hF0, 12'h2, 64'hCAFEF00D00000000, 8'h0, 12'h0);
      vt[10] = mk(1'b0, 2'd3, 1'b0, 64'h10, 64'h0, 64'hCAFEF00D00000000, 3, 1'b0, 1, 8'h0, 12'h2, 64'h0, 8'h0, 12'h0);
      vt[11] = mk(1'b1, 2'd0, 1'b0, 64'h11, 64'hFFFFFFFFFFFFFFAB, 64'hCAFEF00D00000000, 2, 1'b0, 1, 8'h02, 12'h2, 64'h000000000000AB00, 8'h0, 12'h0);
      vt[12] = mk(1'b0, 2'd0, 1'b0, 64'h11, 64'h0, 64'h00000000000000AB, 3, 1'b0, 1, 8'h0, 12'h2, 64'h0, 8'h0, 12'h0);
      vt[13] = mk(1'b0, 2'd0, 1'b1, 64'h11, 64'h0, 64'hFFFFFFFFFFFFFFAB, 3, 1'b0, 1, 8'h0, 12'h2, 64'h0, 8'h0, 12'h0);
      vt[14] = mk(1'b1, 2'd1, 1'b0, 64'h16, 64'hFFFF1234, 64'hFFFFFFFFFFFFFFAB, 2, 1'b0, 1, 8'hC0, 12'h2, 64'h1234000000000000, 8'h0, 12'h0);
      vt[15] = mk(1'b0, 2'd3, 1'b0, 64'h10, 64'h0, 64'h1234F00D0000AB00, 3, 1'b0, 1, 8'h0, 12'h2, 64'h0, 8'h0, 12'h0);
      vt[16] = mk(1'b0, 2'd1, 1'b1, 64'h16, 64'h0, 64'h0000000000001234, 3, 1'b0, 1, 8'h0, 12'h2, 64'h0, 8'h0, 12'h0);
`ifdef DATA_MEM_MISALIGNED_EN
      vt[17] = mk(1'b0, 2'd2, 1'b1, 64'h0A, 64'h0, 64'hFFFFFFFFD0C0B0A0, 3, 1'b0, 1, 8'h0, 12'h1, 64'h0, 8'h0, 12'h0);
      vt[18] = mk(1'b1, 2'd1, 1'b0, 64'h0F, 64'hBEEF, 64'hFFFFFFFFD0C0B0A0, 3, 1'b0, 2, 8'h80, 12'h1, 64'hEF00000000000000, 8'h01, 12'h2);
      vt[19] = mk(1'b0, 2'd1, 1'b1, 64'h0F, 64'h0, 64'hFFFFFFFFFFFFBEEF, 5, 1'b0, 2, 8'h0, 12'h1, 64'h0, 8'h0, 12'h2);
`else
      vt[17] = mk(1'b0, 2'd2, 1'b1, 64'h0A, 64'h0, 64'h0000000000001234, 1, 1'b1, 0, 8'h0, 12'h0, 64'h0, 8'h0, 12'h0);
      vt[18] = mk(1'b1, 2'd1, 1'b0, 64'h0F, 64'hBEEF, 64'h0000000000001234, 1, 1'b1, 0, 8'h0, 12'h0, 64'h0, 8'h0, 12'h0);
      vt[19] = mk(1'b0, 2'd1, 1'b1, 64'h0F, 64'h0, 64'h0000000000001234, 1, 1'b1, 0, 8'h0, 12'h0, 64'h0, 8'h0, 12'h0);
`endif

      // Reset with a request pending: stall must stay low
      rst = 1'b1;
      bif.mem_read = 1'b1; bif.mem_write = 1'b0; bif.bit_width = 2'd3;
      bif.sign_extend = 1'b0; bif.addr = 64'h8; bif.wdata = 64'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_stall", 0, 64'(bif.mem_stall), 64'h0);
      chk("rst_en",    0, 64'(bif.bram_en), 64'h0);
      chk("rst_we",    0, 64'(bif.bram_we), 64'h0);
      chk("rst_valid", 0, 64'(bif.rdata_valid), 64'h0);
      chk("rst_mis",   0, 64'(bif.misaligned), 64'h0);
      chk("rst_rdata", 0, bif.rdata, 64'h0);
      bif.mem_read = 1'b0;
      rst = 1'b0;

      for (int i = 0; i < 20; i++) begin
         run(vt[i].wr, vt[i].bw, vt[i].sx, vt[i].addr, vt[i].wdata);
         chk("stall_c0", i, 64'(o_stall0), 64'h1);
         chk_i("done_cycle", i, o_done, vt[i].exp_done);
         chk_i("valid_cycle", i, o_valid, (!vt[i].wr && !vt[i].exp_mis) ? vt[i].exp_done : -1);
         chk_i("mis_cycle", i, o_mis, vt[i].exp_mis ? 1 : -1);
         chk_i("beats", i, o_beats, vt[i].exp_beats);
         chk("rdata", i, o_rdata, vt[i].exp_rdata);
         if (vt[i].exp_beats > 0) begin
            chk("we0", i, 64'(o_we0), 64'(vt[i].exp_we0));
            chk("addr0", i, 64'(o_ba0), 64'(vt[i].exp_ba0));
            chk("wdata0", i, o_wd0, vt[i].exp_wd0);
         end
         if (vt[i].exp_beats > 1) begin
            chk("we1", i, 64'(o_we1), 64'(vt[i].exp_we1));
            chk("addr1", i, 64'(o_ba1), 64'(vt[i].exp_ba1));
         end
      end

`ifdef DATA_MEM_MISALIGNED_EN
      // Crossing doubleword store then load
      run(1'b1, 2'd3, 1'b0, 64'h0D, 64'h1122334455667788);
      chk_i("sd_x_done", 0, o_done, 3);
      chk("sd_x_we0", 0, 64'(o_we0), 64'hE0);
      chk("sd_x_wd0", 0, o_wd0, 64'h6677880000000000);
      chk("sd_x_we1", 0, 64'(o_we1), 64'h1F);
      chk("sd_x_wd1", 0, o_wd1, 64'h0000001122334455);
      chk("sd_x_addr1", 0, 64'(o_ba1), 64'h2);
      run(1'b0, 2'd3, 1'b0, 64'h0D, 64'h0);
      chk_i("ld_x_valid", 0, o_valid, 5);
      chk("ld_x_rdata", 0, o_rdata, 64'h1122334455667788);
      // Beat1 index wraps past the top of the BRAM
      run(1'b1, 2'd3, 1'b0, 64'h7FF8, 64'h0123456789ABCDEF);
      run(1'b1, 2'd3, 1'b0, 64'h0000, 64'h0F1E2D3C4B5A6978);
      run(1'b0, 2'd3, 1'b0, 64'h7FFC, 64'h0);
      chk("wrap_addr0", 0, 64'(o_ba0), 64'hFFF);
      chk("wrap_addr1", 0, 64'(o_ba1), 64'h000);
      chk("wrap_rdata", 0, o_rdata, 64'h4B5A697801234567);
`else
      // Misaligned store must leave memory untouched
      run(1'b1, 2'd3, 1'b0, 64'h0D, 64'h1122334455667788);
      chk_i("sd_mis_cycle", 0, o_mis, 1);
      chk_i("sd_mis_beats", 0, o_beats, 0);
      run(1'b0, 2'd3, 1'b0, 64'h08, 64'h0);
      chk("sd_mis_mem", 0, o_rdata, 64'hF0E0D0C0B0A09080);
      // Top-of-BRAM aligned word
      run(1'b1, 2'd3, 1'b0, 64'h7FF8, 64'h0123456789ABCDEF);
      run(1'b0, 2'd2, 1'b1, 64'h7FFC, 64'h0);
      chk("top_addr0", 0, 64'(o_ba0), 64'hFFF);
      chk("top_rdata", 0, o_rdata, 64'h0000000001234567);
`endif

      // Reset in WAIT0, then a normal load
      @(negedge clk);
      bif.mem_read = 1'b1; bif.bit_width = 2'd3; bif.sign_extend = 1'b0; bif.addr = 64'h08;
      @(posedge clk);
      #1 bif.mem_read = 1'b0;
      @(posedge clk);
      #1;
      chk("wait0_stall", 0, 64'(bif.mem_stall), 64'h1);
      bif.mem_read = 1'b1;
      rst = 1'b1;
      #1;
      chk("rstw_stall", 0, 64'(bif.mem_stall), 64'h0);
      chk("rstw_en",    0, 64'(bif.bram_en), 64'h0);
      chk("rstw_rdata", 0, bif.rdata, 64'h0);
      chk("rstw_valid", 0, 64'(bif.rdata_valid), 64'h0);
      @(negedge clk);
      bif.mem_read = 1'b0;
      rst = 1'b0;
      run(1'b0, 2'd2, 1'b0, 64'h08, 64'h0);
      chk_i("post_rst_valid", 0, o_valid, 3);
      chk("post_rst_rdata", 0, o_rdata, 64'h00000000B0A09080);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
